// File: rtl/sm83_fetch.sv
// SM83 instruction fetch stage.
// Reads opcode bytes from memory, folds the 0xCB prefix, and collects up to
// two little-endian immediate bytes. The finished instruction is held for the
// decoder until it is accepted. A redirect aborts any fetch and restarts at a
// new PC.

module sm83_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  dec_opcode,
  output logic        dec_cb,
  output logic [15:0] dec_imm,
  output logic [1:0]  dec_imm_len,
  output logic [15:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  typedef enum logic [2:0] {
    FETCH_OP,
    FETCH_CB,
    FETCH_IMM_LO,
    FETCH_IMM_HI,
    HOLD
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [1:0]  op_len;

  // Immediate byte count for an unprefixed opcode; anything not listed,
  // including the illegal opcodes, carries no immediate.
  function automatic logic [1:0] imm_len_of(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10,
      8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:
        imm_len_of = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
      8'hEA, 8'hFA:
        imm_len_of = 2'd2;
      default:
        imm_len_of = 2'd0;
    endcase
  endfunction

  // Length lookup of the byte currently on the read bus.
  always_comb begin
    op_len = imm_len_of(mem_rdata);
  end

  assign pc_inc   = pc + 16'd1;
  assign mem_addr = pc;
  // Reads are requested in every fetch state; nothing is prefetched while an
  // instruction waits for the decoder, and the bus is quiet during reset.
  assign mem_rd   = !rst && (state != HOLD);

  // Fetch sequencer: redirect beats everything, then each acknowledged byte
  // advances the PC and steps through opcode, prefix and immediate bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_OP;
      pc          <= RESET_PC;
      dec_valid   <= 1'b0;
      dec_opcode  <= 8'h00;
      dec_cb      <= 1'b0;
      dec_imm     <= 16'h0000;
      dec_imm_len <= 2'd0;
      dec_pc      <= 16'h0000;
    end else if (redirect_valid) begin
      pc        <= redirect_pc;
      state     <= FETCH_OP;
      dec_valid <= 1'b0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (mem_ack) begin
            pc      <= pc_inc;
            dec_pc  <= pc;
            dec_cb  <= 1'b0;
            dec_imm <= 16'h0000;
            if (mem_rdata == 8'hCB) begin
              state <= FETCH_CB;
            end else begin
              dec_opcode  <= mem_rdata;
              dec_imm_len <= op_len;
              if (op_len == 2'd0) begin
                state     <= HOLD;
                dec_valid <= 1'b1;
              end else begin
                state <= FETCH_IMM_LO;
              end
            end
          end
        end
        FETCH_CB: begin
          if (mem_ack) begin
            pc          <= pc_inc;
            dec_opcode  <= mem_rdata;
            dec_cb      <= 1'b1;
            dec_imm_len <= 2'd0;
            state       <= HOLD;
            dec_valid   <= 1'b1;
          end
        end
        FETCH_IMM_LO: begin
          if (mem_ack) begin
            pc           <= pc_inc;
            dec_imm[7:0] <= mem_rdata;
            if (dec_imm_len == 2'd1) begin
              state     <= HOLD;
              dec_valid <= 1'b1;
            end else begin
              state <= FETCH_IMM_HI;
            end
          end
        end
        FETCH_IMM_HI: begin
          if (mem_ack) begin
            pc            <= pc_inc;
            dec_imm[15:8] <= mem_rdata;
            state         <= HOLD;
            dec_valid     <= 1'b1;
          end
        end
        HOLD: begin
          if (dec_valid && dec_ready) begin
            state     <= FETCH_OP;
            dec_valid <= 1'b0;
          end
        end
        default: begin
          state     <= FETCH_OP;
          dec_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
